// File: rtl/battle_sequencer.sv
// Auto-battle sequencer: loads both teams, resolves front-pet hits
// round by round and reports the outcome to the control FSM.
module battle_sequencer #(
    parameter int N_SLOTS    = 5,
    parameter int STAT_W     = 6,
    parameter int ROUND_DLY  = 4,
    parameter int MAX_ROUNDS = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [3:0]            team_rd_addr,
    input  logic [2*STAT_W-1:0]   team_rd_data,
    output logic                  busy,
    output logic                  battleDone,
    output logic                  battleWin,
    output logic                  battleTie,
    output logic [2:0]            front_a,
    output logic [2:0]            front_b,
    output logic [STAT_W-1:0]     hp_a,
    output logic [STAT_W-1:0]     hp_b,
    output logic [4:0]            round
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SKIP = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_HIT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int DLY_W = (ROUND_DLY > 1) ? $clog2(ROUND_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ROUND_DLY - 1);
    localparam logic [2:0] NS = 3'(N_SLOTS);
    localparam logic [3:0] LD_LAST = 4'(2 * N_SLOTS);
    localparam logic [4:0] RND_LAST = 5'(MAX_ROUNDS - 1);

    logic [2:0]        state;
    logic [3:0]        ld_cnt;
    logic [3:0]        cap_addr;
    logic              cap_vld;
    logic [DLY_W-1:0]  wcnt;
    logic              capped;

    logic [STAT_W-1:0] atk_a_m [N_SLOTS];
    logic [STAT_W-1:0] hp_a_m  [N_SLOTS];
    logic [STAT_W-1:0] atk_b_m [N_SLOTS];
    logic [STAT_W-1:0] hp_b_m  [N_SLOTS];

    logic              exh_a, exh_b;
    logic              adv_a, adv_b;
    logic [2:0]        fa_i, fb_i;
    logic [STAT_W-1:0] atk_cur_a, atk_cur_b;
    logic [3:0]        slot_w;
    logic              ld_drive;

    assign exh_a = (front_a == NS);
    assign exh_b = (front_b == NS);
    assign fa_i  = exh_a ? 3'd0 : front_a;
    assign fb_i  = exh_b ? 3'd0 : front_b;

    assign hp_a      = exh_a ? '0 : hp_a_m[fa_i];
    assign hp_b      = exh_b ? '0 : hp_b_m[fb_i];
    assign atk_cur_a = atk_a_m[fa_i];
    assign atk_cur_b = atk_b_m[fb_i];

    assign adv_a = !exh_a && (hp_a == '0);
    assign adv_b = !exh_b && (hp_b == '0);

    // A slots occupy addresses 0..N-1, B slots 8..8+N-1
    assign ld_drive = (state == S_LOAD) && (ld_cnt < LD_LAST);
    assign slot_w   = (ld_cnt >= 4'(N_SLOTS)) ? ld_cnt - 4'(N_SLOTS)
                                              : ld_cnt;
    assign team_rd_addr = ld_drive
        ? {(ld_cnt >= 4'(N_SLOTS)), slot_w[2:0]} : 4'd0;

    assign busy       = (state != S_IDLE);
    assign battleDone = (state == S_DONE);
    assign battleTie  = battleDone && (capped || (exh_a && exh_b));
    assign battleWin  = battleDone && !capped && exh_b && !exh_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ld_cnt   <= '0;
            cap_addr <= '0;
            cap_vld  <= 1'b0;
            wcnt     <= '0;
            capped   <= 1'b0;
            front_a  <= '0;
            front_b  <= '0;
            round    <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                atk_a_m[i] <= '0;
                hp_a_m[i]  <= '0;
                atk_b_m[i] <= '0;
                hp_b_m[i]  <= '0;
            end
        end else begin
            cap_vld  <= ld_drive;
            cap_addr <= team_rd_addr;
            if (cap_vld) begin
                if (cap_addr[3]) begin
                    atk_b_m[cap_addr[2:0]] <= team_rd_data[2*STAT_W-1:STAT_W];
                    hp_b_m[cap_addr[2:0]]  <= team_rd_data[STAT_W-1:0];
                end else begin
                    atk_a_m[cap_addr[2:0]] <= team_rd_data[2*STAT_W-1:STAT_W];
                    hp_a_m[cap_addr[2:0]]  <= team_rd_data[STAT_W-1:0];
                end
            end

            unique case (state)
                S_IDLE: begin
                    round   <= '0;
                    front_a <= '0;
                    front_b <= '0;
                    capped  <= 1'b0;
                    ld_cnt  <= '0;
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (ld_cnt == LD_LAST) state <= S_SKIP;
                    else ld_cnt <= ld_cnt + 4'd1;
                end
                S_SKIP: begin
                    if (adv_a) front_a <= front_a + 3'd1;
                    if (adv_b) front_b <= front_b + 3'd1;
                    if (!adv_a && !adv_b) begin
                        wcnt  <= '0;
                        state <= (exh_a || exh_b) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == DLY_LAST) state <= S_HIT;
                    else wcnt <= wcnt + 1'b1;
                end
                S_HIT: begin
                    // both sides use pre-hit values: simultaneous exchange
                    hp_a_m[fa_i] <= (hp_a > atk_cur_b) ? hp_a - atk_cur_b : '0;
                    hp_b_m[fb_i] <= (hp_b > atk_cur_a) ? hp_b - atk_cur_a : '0;
                    round <= round + 5'd1;
                    if (round == RND_LAST) begin
                        capped <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_SKIP;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer against a
// round-by-round battle model with cycle accounting.
module tb_battle_sequencer;

    localparam int N  = 5;
    localparam int W  = 6;
    localparam int D  = 4;
    localparam int MR = 31;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [3:0]     team_rd_addr;
    logic [2*W-1:0] team_rd_data;
    logic           busy, battleDone, battleWin, battleTie;
    logic [2:0]     front_a, front_b;
    logic [W-1:0]   hp_a, hp_b;
    logic [4:0]     round;

    logic [2*W-1:0] mem [16];
    int a_atk [N];
    int a_hp  [N];
    int b_atk [N];
    int b_hp  [N];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    battle_sequencer #(
        .N_SLOTS(N), .STAT_W(W), .ROUND_DLY(D), .MAX_ROUNDS(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .team_rd_addr(team_rd_addr), .team_rd_data(team_rd_data),
        .busy(busy), .battleDone(battleDone),
        .battleWin(battleWin), .battleTie(battleTie),
        .front_a(front_a), .front_b(front_b),
        .hp_a(hp_a), .hp_b(hp_b), .round(round)
    );

    always #5 clk = ~clk;

    always @(posedge clk) team_rd_data <= mem[team_rd_addr];

    always @(negedge clk) if (battleDone === 1'b1) done_cnt++;

    task automatic clear_teams();
        for (int i = 0; i < N; i++) begin
            a_atk[i] = 0; a_hp[i] = 0; b_atk[i] = 0; b_hp[i] = 0;
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < N; i++) begin
            mem[i]     = {W'(a_atk[i]), W'(a_hp[i])};
            mem[8 + i] = {W'(b_atk[i]), W'(b_hp[i])};
        end
    endtask

    // res: 0 loss, 1 win, 2 tie; lat/fk are edges counted from the start edge
    task automatic model(output int res, output int rnd, output int lat,
                         output int efa, output int efb,
                         output int eha, output int ehb,
                         output int ffa, output int ffb, output int fk);
        int ha [N];
        int hb [N];
        int fa, fb, sa, sb, na, nb;
        for (int i = 0; i < N; i++) begin ha[i] = a_hp[i]; hb[i] = b_hp[i]; end
        fa = 0; fb = 0; rnd = 0; lat = 2 * N + 1;
        fk = -1; ffa = 0; ffb = 0; res = 0;
        while (1) begin
            sa = 0; sb = 0;
            while (fa < N && ha[fa] == 0) begin fa++; sa++; end
            while (fb < N && hb[fb] == 0) begin fb++; sb++; end
            lat += ((sa > sb) ? sa : sb) + 1;
            if (fa == N || fb == N) begin
                res = (fa == N && fb == N) ? 2 : (fb == N) ? 1 : 0;
                break;
            end
            if (fk < 0) begin fk = lat; ffa = fa; ffb = fb; end
            lat += D + 1;
            na = ha[fa] - b_atk[fb];
            nb = hb[fb] - a_atk[fa];
            ha[fa] = (na < 0) ? 0 : na;
            hb[fb] = (nb < 0) ? 0 : nb;
            rnd++;
            if (rnd == MR) begin res = 2; break; end
        end
        efa = fa; efb = fb;
        eha = (fa < N) ? ha[fa] : 0;
        ehb = (fb < N) ? hb[fb] : 0;
    endtask

    task automatic run_battle(input string nm, input int inject_k);
        int res, rnd, lat, efa, efb, eha, ehb, ffa, ffb, fk, k;
        load_mem();
        model(res, rnd, lat, efa, efb, eha, ehb, ffa, ffb, fk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: got %b want 1", nm, busy);
        end
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (k == fk) begin
                checks++;
                if ({front_a, front_b} !== {3'(ffa), 3'(ffb)}) begin
                    failures++;
                    $display("FAIL %s first_fronts: got %0d/%0d want %0d/%0d",
                             nm, front_a, front_b, ffa, ffb);
                end
            end
            if (battleDone === 1'b1) break;
            start = (k == inject_k);
        end
        start = 1'b0;
        checks++;
        if (battleDone !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: no battleDone after %0d cycles", nm, k);
            reset = 1'b0; @(negedge clk); reset = 1'b1;
            return;
        end
        if (k != lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", nm, k, lat);
        end
        checks++;
        if ({battleWin, battleTie} !== {1'(res == 1), 1'(res == 2)}) begin
            failures++;
            $display("FAIL %s outcome: got win=%b tie=%b want res=%0d",
                     nm, battleWin, battleTie, res);
        end
        checks++;
        if (round !== 5'(rnd)) begin
            failures++;
            $display("FAIL %s round: got %0d want %0d", nm, round, rnd);
        end
        checks++;
        if ({front_a, front_b} !== {3'(efa), 3'(efb)}) begin
            failures++;
            $display("FAIL %s fronts: got %0d/%0d want %0d/%0d",
                     nm, front_a, front_b, efa, efb);
        end
        checks++;
        if ({hp_a, hp_b} !== {W'(eha), W'(ehb)}) begin
            failures++;
            $display("FAIL %s hp: got %0d/%0d want %0d/%0d",
                     nm, hp_a, hp_b, eha, ehb);
        end
        @(negedge clk);
        checks++;
        if ({busy, battleDone, battleWin, battleTie} !== 4'b0000) begin
            failures++;
            $display("FAIL %s after_done: got %b want 0000",
                     nm, {busy, battleDone, battleWin, battleTie});
        end
    endtask

    task automatic test_reset();
        int dc;
        logic [30:0] outs;
        start = 1'b0;
        reset = 1'b0;
        clear_teams();
        load_mem();
        repeat (2) @(negedge clk);
        outs = {team_rd_addr, busy, battleDone, battleWin, battleTie,
                front_a, front_b, hp_a, hp_b, round};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_init: got %h want 0", outs);
        end
        reset = 1'b1;
        a_atk[0] = 3; a_hp[0] = 4; b_atk[0] = 2; b_hp[0] = 3;
        load_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        dc = done_cnt;
        reset = 1'b0;
        start = 1'b1;
        #1;
        outs = {team_rd_addr, busy, battleDone, battleWin, battleTie,
                front_a, front_b, hp_a, hp_b, round};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_async: got %h want 0", outs);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            outs = {team_rd_addr, busy, battleDone, battleWin, battleTie,
                    front_a, front_b, hp_a, hp_b, round};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_hold%0d: got %h want 0", i, outs);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != dc) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b dones=%0d want 0/%0d",
                     busy, done_cnt, dc);
        end
    endtask

    task automatic test_single_duel();
        clear_teams();
        a_atk[0] = 3; a_hp[0] = 4; b_atk[0] = 2; b_hp[0] = 3;
        run_battle("single_duel", 0);
    endtask

    task automatic test_trade_advance();
        clear_teams();
        a_atk[0] = 2; a_hp[0] = 2; a_atk[1] = 1; a_hp[1] = 5;
        b_atk[0] = 2; b_hp[0] = 2; b_atk[1] = 3; b_hp[1] = 1;
        run_battle("trade_advance", 0);
    endtask

    task automatic test_mutual_wipe();
        clear_teams();
        a_atk[0] = 5; a_hp[0] = 5; b_atk[0] = 5; b_hp[0] = 5;
        run_battle("mutual_wipe", 0);
    endtask

    task automatic test_empty_and_loss();
        clear_teams();
        a_atk[2] = 1; a_hp[2] = 1; b_atk[0] = 4; b_hp[0] = 9;
        run_battle("empty_loss", 0);
        clear_teams();
        a_atk[0] = 1; a_hp[0] = 1; b_atk[0] = 9; b_hp[0] = 2;
        run_battle("saturation", 0);
        clear_teams();
        b_atk[3] = 2; b_hp[3] = 2;
        run_battle("empty_a", 0);
        clear_teams();
        run_battle("both_empty", 0);
    endtask

    task automatic test_round_cap();
        clear_teams();
        a_hp[0] = 9; b_hp[0] = 9;
        run_battle("round_cap", 2 * N + 3);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) begin
                a_atk[i] = $urandom_range(0, 12);
                b_atk[i] = $urandom_range(0, 12);
                a_hp[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
                b_hp[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            end
            run_battle($sformatf("random%0d", t), $urandom_range(1, 10));
        end
    endtask

    initial begin
        test_reset();
        test_single_duel();
        test_trade_advance();
        test_mutual_wipe();
        test_empty_and_loss();
        test_round_cap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
